// File: rtl/vc_mem_fixed_latency_responder.sv
// Purpose: fixed-latency val/rdy memory responder backed by an internal byte-addressed array.
// Latency: p_latency cycles from request accept to earliest response valid; one request per cycle.
// Backpressure: responses queue (p_depth deep) under memresp_rdy=0; memreq_rdy drops once p_depth requests are outstanding.
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   memreq_val/rdy/msg  request  {type[66], addr[65:34], len[33:32], data[31:0]}
//   memresp_val/rdy/msg response {type[34], len[33:32], data[31:0]}
//   mem_err             one-cycle pulse the cycle after accepting a bad request
// Optional: define VC_MEM_RESPONDER_ADDR_CHECK_EN to flag out-of-range or word-crossing
// requests (writes dropped, reads return 32'hDEADBEEF, mem_err pulses). Without it,
// addresses wrap modulo p_mem_sz, excess lanes are dropped and mem_err is tied 0.

module vc_mem_fixed_latency_responder #(
    parameter int p_mem_sz  = 1 << 20,
    parameter int p_latency = 2,
    parameter int p_depth   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memreq_val,
    output logic        memreq_rdy,
    input  logic [66:0] memreq_msg,
    output logic        memresp_val,
    input  logic        memresp_rdy,
    output logic [34:0] memresp_msg,
    output logic        mem_err
);

    localparam int AW = $clog2(p_mem_sz);
    localparam int QW = (p_depth > 1) ? $clog2(p_depth) : 1;
    localparam int CW = $clog2(p_depth + 1);

    typedef struct packed {
        logic        typ;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } req_t;

    typedef struct packed {
        logic        typ;
        logic [1:0]  len;
        logic [31:0] data;
    } resp_t;

    req_t req;
    assign req = memreq_msg;

    logic accept;
    logic pop;
    assign accept = memreq_val && memreq_rdy;
    assign pop    = memresp_val && memresp_rdy;

    // ------------------------------------------------------------------
    // Byte lanes: lane k carries byte addr+k; lanes past byte 3 of the
    // word are disabled rather than spilling into the next word.
    // ------------------------------------------------------------------
    logic [7:0]    mem [p_mem_sz];
    logic [1:0]    req_off;
    logic [2:0]    req_nbytes;
    logic [3:0]    lane_en;
    logic [AW-1:0] lane_addr [4];
    logic [31:0]   rd_data;
    logic          req_flag;

    assign req_off    = req.addr[1:0];
    assign req_nbytes = (req.len == 2'd0) ? 3'd4 : {1'b0, req.len};

    for (genvar k = 0; k < 4; k++) begin : g_lane
        logic [2:0] lane_pos;
        assign lane_pos        = {1'b0, req_off} + 3'(k);
        assign lane_en[k]      = (3'(k) < req_nbytes) && !lane_pos[2];
        assign lane_addr[k]    = {req.addr[AW-1:2], lane_pos[1:0]};
        assign rd_data[8*k +: 8] = lane_en[k] ? mem[lane_addr[k]] : 8'h00;
    end

`ifdef VC_MEM_RESPONDER_ADDR_CHECK_EN
    assign req_flag = (req.addr >= 32'(p_mem_sz))
                   || ((4'(req_off) + 4'(req_nbytes)) > 4'd4);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_err <= 1'b0;
        end else begin
            mem_err <= accept && req_flag;
        end
    end
`else
    assign req_flag = 1'b0;
    assign mem_err  = 1'b0;

    // High address bits are ignored: the array wraps.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req.addr[31:AW];
`endif

    logic wr_fire;
    assign wr_fire = accept && req.typ && !req_flag;

    // Array contents survive reset, so this block has no reset branch.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int k = 0; k < 4; k++) begin
                if (lane_en[k]) begin
                    mem[lane_addr[k]] <= req.data[8*k +: 8];
                end
            end
        end
    end

    resp_t acc_resp;
    always_comb begin
        acc_resp      = '0;
        acc_resp.typ  = req.typ;
        acc_resp.len  = req.len;
        if (!req.typ) begin
            acc_resp.data = req_flag ? 32'hDEADBEEF : rd_data;
        end
    end

    // ------------------------------------------------------------------
    // Latency pipe: an entry loaded at edge N reaches the last stage at
    // edge N+p_latency-1 and is enqueued at edge N+p_latency.
    // ------------------------------------------------------------------
    logic [p_latency-1:0] pipe_val;
    resp_t                pipe_dat [p_latency];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_val <= '0;
            for (int i = 0; i < p_latency; i++) begin
                pipe_dat[i] <= '0;
            end
        end else begin
            pipe_val[0] <= accept;
            pipe_dat[0] <= acc_resp;
            for (int i = 1; i < p_latency; i++) begin
                pipe_val[i] <= pipe_val[i-1];
                pipe_dat[i] <= pipe_dat[i-1];
            end
        end
    end

    logic  enq;
    resp_t enq_dat;
    assign enq     = pipe_val[p_latency-1];
    assign enq_dat = pipe_dat[p_latency-1];

    // ------------------------------------------------------------------
    // Response queue. The outstanding limit guarantees it never overflows:
    // when it holds p_depth entries the pipe is empty, so enq and full
    // only coincide with a pop.
    // ------------------------------------------------------------------
    resp_t          q_mem [p_depth];
    logic [QW-1:0]  q_wr;
    logic [QW-1:0]  q_rd;
    logic [CW-1:0]  q_cnt;
    logic [CW-1:0]  outst;

    function automatic logic [QW-1:0] ptr_inc(input logic [QW-1:0] p);
        return (p == QW'(p_depth - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (enq) begin
            q_mem[q_wr] <= enq_dat;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_wr  <= '0;
            q_rd  <= '0;
            q_cnt <= '0;
            outst <= '0;
        end else begin
            if (enq) begin
                q_wr <= ptr_inc(q_wr);
            end
            if (pop) begin
                q_rd <= ptr_inc(q_rd);
            end
            case ({enq, pop})
                2'b10:   q_cnt <= q_cnt + 1'b1;
                2'b01:   q_cnt <= q_cnt - 1'b1;
                default: q_cnt <= q_cnt;
            endcase
            case ({accept, pop})
                2'b10:   outst <= outst + 1'b1;
                2'b01:   outst <= outst - 1'b1;
                default: outst <= outst;
            endcase
        end
    end

    assign memreq_rdy  = (outst < CW'(p_depth));
    assign memresp_val = (q_cnt != '0);
    // Queue storage is not reset; mask the head so an idle port reads 0.
    assign memresp_msg = memresp_val ? q_mem[q_rd] : '0;

endmodule

// File: tb/tb_vc_mem_fixed_latency_responder.sv
module tb_vc_mem_fixed_latency_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        memreq_val;
    logic        memreq_rdy;
    logic [66:0] memreq_msg;
    logic        memresp_val;
    logic        memresp_rdy;
    logic [34:0] memresp_msg;
    logic        mem_err;

    vc_mem_fixed_latency_responder #(
        .p_mem_sz  (1 << 20),
        .p_latency (2),
        .p_depth   (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .memreq_val  (memreq_val),
        .memreq_rdy  (memreq_rdy),
        .memreq_msg  (memreq_msg),
        .memresp_val (memresp_val),
        .memresp_rdy (memresp_rdy),
        .memresp_msg (memresp_msg),
        .mem_err     (mem_err)
    );

    always #5 clk = ~clk;

`ifdef VC_MEM_RESPONDER_ADDR_CHECK_EN
    localparam logic [31:0] X_CROSS = 32'hDEADBEEF;
    localparam logic [31:0] X_OOR   = 32'hDEADBEEF;
    localparam logic        X_ERR   = 1'b1;
`else
    localparam logic [31:0] X_CROSS = 32'h000000AB;
    localparam logic [31:0] X_OOR   = 32'h13579BDF;
    localparam logic        X_ERR   = 1'b0;
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [34:0] exp_q [$];
    int          run_len    = 0;
    int          run_start  = 0;
    int          prev_resp  = -10;
    logic [31:0] t3_dat [4];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [66:0] rq(input logic t, input logic [31:0] a,
                                       input logic [1:0] l, input logic [31:0] d);
        return {t, a, l, d};
    endfunction

    function automatic logic [34:0] rsp(input logic t, input logic [1:0] l, input logic [31:0] d);
        return {t, l, d};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Response monitor: a response seen here is consumed at the next rising edge.
    always @(negedge clk) begin
        if (!reset && memresp_val && memresp_rdy) begin
            if (exp_q.size() == 0) begin
                check("resp_unexpected", 64'(exp_q.size()), 64'd1);
            end else begin
                check("resp", 64'(memresp_msg), 64'(exp_q.pop_front()));
            end
            if (cyc == prev_resp + 1) begin
                run_len++;
            end else begin
                run_len   = 1;
                run_start = cyc;
            end
            prev_resp = cyc;
        end
    end

    task automatic send(input logic t, input logic [31:0] a, input logic [1:0] l, input logic [31:0] d);
        bit ok;
        ok = 1'b0;
        memreq_val = 1'b1;
        memreq_msg = rq(t, a, l, d);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (memreq_rdy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("send_timeout", 64'(ok), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        memreq_val = 1'b0;
        memreq_msg = '0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) break;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int t4_acc0;
        int t4_last;

        t3_dat[0] = 32'hABFE3344;
        t3_dat[1] = 32'h00000044;
        t3_dat[2] = 32'h00003344;
        t3_dat[3] = 32'h00FE3344;

        reset       = 1'b1;
        memreq_val  = 1'b0;
        memreq_msg  = '0;
        memresp_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_rdy",   64'(memreq_rdy),  64'd1);
        check("rst_resp_val",  64'(memresp_val), 64'd0);
        check("rst_resp_msg",  64'(memresp_msg), 64'd0);
        check("rst_mem_err",   64'(mem_err),     64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Write then read back the same word; check the round-trip latency.
        send(1'b1, 32'h100, 2'd0, 32'hCAFEBABE);
        exp_q.push_back(rsp(1'b1, 2'd0, 32'h0));
        send(1'b0, 32'h100, 2'd0, 32'h0);
        exp_q.push_back(rsp(1'b0, 2'd0, 32'hCAFEBABE));
        check("t1_val_early", 64'(memresp_val), 64'd0);
        idle();
        @(posedge clk);
        #1;
        check("t1_val_lat2", 64'(memresp_val), 64'd1);
        wait_drain();

        // Sub-word accesses. Word 0x100 holds bytes BE BA FE CA.
        send(1'b1, 32'h103, 2'd1, 32'hFFFFFFAB);
        exp_q.push_back(rsp(1'b1, 2'd1, 32'h0));
        send(1'b0, 32'h102, 2'd2, 32'h0);
        exp_q.push_back(rsp(1'b0, 2'd2, 32'h0000ABFE));
        send(1'b0, 32'h101, 2'd3, 32'h0);
        exp_q.push_back(rsp(1'b0, 2'd3, 32'h00ABFEBA));
        send(1'b0, 32'h103, 2'd2, 32'h0);
        exp_q.push_back(rsp(1'b0, 2'd2, X_CROSS));
        send(1'b1, 32'h100, 2'd2, 32'h11223344);
        exp_q.push_back(rsp(1'b1, 2'd2, 32'h0));
        send(1'b0, 32'h100, 2'd0, 32'h0);
        exp_q.push_back(rsp(1'b0, 2'd0, 32'hABFE3344));
        idle();
        wait_drain();

        // Response backpressure: only p_depth requests may be outstanding.
        memresp_rdy = 1'b0;
        acc = 0;
        memreq_val = 1'b1;
        for (int c = 0; c < 8; c++) begin
            memreq_msg = rq(1'b0, 32'h100, 2'(acc), 32'h0);
            @(negedge clk);
            if (memreq_rdy && acc < 6) begin
                exp_q.push_back(rsp(1'b0, 2'(acc), t3_dat[acc % 4]));
                acc++;
            end
            @(posedge clk);
            #1;
        end
        idle();
        check("t3_accepts",  64'(acc),         64'd4);
        check("t3_req_rdy",  64'(memreq_rdy),  64'd0);
        check("t3_resp_val", 64'(memresp_val), 64'd1);
        check("t3_head",     64'(memresp_msg), 64'(rsp(1'b0, 2'd0, 32'hABFE3344)));
        memresp_rdy = 1'b1;
        wait_drain();
        check("t3_req_rdy_back", 64'(memreq_rdy), 64'd1);

        // Full throughput with the response port always ready.
        acc = 0;
        t4_acc0 = -1;
        t4_last = -1;
        memreq_val = 1'b1;
        for (int c = 0; c < 40 && acc < 20; c++) begin
            memreq_msg = rq(1'b0, 32'h100, 2'(acc), 32'h0);
            @(negedge clk);
            if (memreq_rdy) begin
                if (acc == 0) t4_acc0 = cyc;
                t4_last = cyc;
                exp_q.push_back(rsp(1'b0, 2'(acc), t3_dat[acc % 4]));
                acc++;
            end
            @(posedge clk);
            #1;
        end
        idle();
        check("t4_accepts", 64'(acc), 64'd20);
        check("t4_span",    64'(t4_last - t4_acc0), 64'd19);
        wait_drain();
        check("t4_run", 64'(run_len), 64'd20);
        check("t4_lat", 64'(run_start - t4_acc0), 64'd3);

        // Reset with responses in flight; accepted writes must survive.
        send(1'b1, 32'h200, 2'd0, 32'h5A5AA5A5);
        exp_q.push_back(rsp(1'b1, 2'd0, 32'h0));
        idle();
        wait_drain();
        memresp_rdy = 1'b0;
        send(1'b0, 32'h200, 2'd0, 32'h0);
        send(1'b0, 32'h200, 2'd1, 32'h0);
        send(1'b0, 32'h200, 2'd2, 32'h0);
        idle();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("t5_val_before", 64'(memresp_val), 64'd1);
        check("t5_rdy_before", 64'(memreq_rdy),  64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("t5_val_rst", 64'(memresp_val), 64'd0);
        check("t5_rdy_rst", 64'(memreq_rdy),  64'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        memresp_rdy = 1'b1;
        send(1'b0, 32'h200, 2'd0, 32'h0);
        exp_q.push_back(rsp(1'b0, 2'd0, 32'h5A5AA5A5));
        idle();
        wait_drain();

        // Address just past the array.
        send(1'b1, 32'h0, 2'd0, 32'h13579BDF);
        exp_q.push_back(rsp(1'b1, 2'd0, 32'h0));
        check("t6_err_inrange", 64'(mem_err), 64'd0);
        send(1'b0, 32'h00100000, 2'd0, 32'h0);
        exp_q.push_back(rsp(1'b0, 2'd0, X_OOR));
        check("t6_err_pulse", 64'(mem_err), 64'(X_ERR));
        idle();
        @(posedge clk);
        #1;
        check("t6_err_clear", 64'(mem_err), 64'd0);
        wait_drain();

        check("end_queue", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
